uart_rx_oversampled: RTL and testbench
======================================

Name: uart_rx_oversampled

Overview:
- Standalone UART receiver that recovers frames from an asynchronous serial line by oversampling at CLOCKS_PER_BIT system clocks per bit.
- Frame format: 1 start bit (0), INPUT_DATA_WIDTH data bits LSB first, an optional parity bit, 1 stop bit (1).
- Connects to the serial output of our UART transmitter, either in loopback or as an external pin.
- Delivers each byte with a one-cycle valid pulse, and flags parity and framing errors separately.

Parameters:
- INPUT_DATA_WIDTH, 8, number of data bits per frame.
- PARITY_ENABLED, 1, 1 means a parity bit follows the data bits; 0 means no parity bit.
- PARITY_TYPE, 0, 0 selects even parity (parity bit = ^data); 1 selects odd parity (~^data).
- CLOCKS_PER_BIT, 8, system clocks per bit period. Must be even and ≥4.
- NUMBER_OF_RX_SYNCHRONIZERS, 3, depth of the flip-flop chain on serial_in.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- serial_in  input  1  asynchronous serial line; idles high.
- received_data  output  INPUT_DATA_WIDTH  last correctly received word. Updated only when data_is_valid fires.
- data_is_valid  output  1  one-cycle pulse: frame good, with correct parity and a stop bit of 1.
- rx_error  output  1  one-cycle pulse: parity mismatch. Stop bit was good.
- framing_error  output  1  one-cycle pulse: stop bit sampled as 0.
- o_busy  output  1  high in every state except IDLE.

Behaviour:
- Reset, synchronous:
  - Synchronizer flops are set to 1; rx_s denotes the synchronizer output.
  - State goes to IDLE; the bit counter, bit index and shift register go to 0.
  - received_data=0; data_is_valid=0; rx_error=0; framing_error=0; o_busy=0.
  - A reset mid-frame aborts the frame with no pulse.
- States: IDLE, START, DATA, PARITY, STOP, WAIT_HIGH. A free counter cnt (width clog2(CLOCKS_PER_BIT)) drives all sampling.
- IDLE:
  - On rx_s==0: go to START with cnt<=0.
- START:
  - cnt increments each clock.
  - At cnt==CLOCKS_PER_BIT/2-1, sample rx_s. This is the mid-start-bit check.
  - If the sample is 0: go to DATA, with cnt<=0 and bit index <=0.
  - If the sample is 1: this is a glitch (false start); return to IDLE with no pulse.
- DATA:
  - At cnt==CLOCKS_PER_BIT-1, shift rx_s into bit[index], set cnt<=0 and increment index.
  - After bit INPUT_DATA_WIDTH-1: go to PARITY if PARITY_ENABLED, else go to STOP.
- PARITY:
  - At cnt==CLOCKS_PER_BIT-1, latch the parity sample and go to STOP with cnt<=0.
- STOP, at cnt==CLOCKS_PER_BIT-1:
  - If rx_s==1 and parity is good (or parity is disabled): data_is_valid<=1 and received_data<=shift register. Go to IDLE.
  - If rx_s==1 and parity is bad: rx_error<=1 and received_data is unchanged. Go to IDLE.
  - If rx_s==0: framing_error<=1 and received_data is unchanged. Go to WAIT_HIGH. Parity is not reported in this case.
- WAIT_HIGH:
  - Stays until rx_s==1, then goes to IDLE. This prevents a break condition from being decoded as repeated frames.
- Pulse rules:
  - All three pulses are registered and last exactly one cycle.
  - At most one of the three is high in any cycle.
- Latency. Let k be the first clk edge at which serial_in==0 is captured.
  - FSM enters START at edge k+NUMBER_OF_RX_SYNCHRONIZERS.
  - Stop bit is sampled at edge k+NUMBER_OF_RX_SYNCHRONIZERS+CLOCKS_PER_BIT/2+(INPUT_DATA_WIDTH+PARITY_ENABLED+1)*CLOCKS_PER_BIT. That is k+87 with the defaults.
  - The pulse is high for the cycle following that edge.
- Back-to-back frames:
  - A new start bit may begin immediately after the stop-bit sample edge.
  - IDLE accepts rx_s==0 on the very next cycle, so a transmitter sending frames with zero idle gap is received without loss.
- Clock tolerance:
  - Sampling is at mid-bit, so it tolerates ±(CLOCKS_PER_BIT/2-1) clocks of cumulative drift across a frame.

Test Plan:
- Default parameters; drive frame 0x5A with even parity bit 0 and stop 1, CLOCKS_PER_BIT clocks per bit, serial_in first low at edge k -> data_is_valid pulses one cycle after edge k+87, received_data=0x5A, rx_error=0, framing_error=0, o_busy drops in the same cycle.
- Frame 0xA5 with parity bit forced to 1 (wrong for even parity) -> rx_error one-cycle pulse; data_is_valid=0; received_data keeps its previous value 0x5A.
- Frame 0x3C with stop bit 0, then the line held low for 40 clocks -> single framing_error pulse, FSM stays in WAIT_HIGH with o_busy=1 and no further pulses; after the line goes high, a valid 0x81 frame is received correctly.
- serial_in low glitch of 2 clocks -> START entered, mid-bit sample reads 1, return to IDLE, no pulses, received_data unchanged.
- Two frames 0x00 and 0xFF back-to-back with no idle gap -> two data_is_valid pulses exactly (INPUT_DATA_WIDTH+PARITY_ENABLED+2)*CLOCKS_PER_BIT=88 cycles apart, with the correct data each time.
- Reset asserted mid-DATA of a frame -> next cycle all outputs are 0 and the FSM is in IDLE; no pulse for the aborted frame; the next full frame 0x42 is received correctly. Also run this with PARITY_ENABLED=0: latency shrinks by 8 cycles and no parity is checked.

Source files
------------

// File: rtl/uart_rx_oversampled.sv
// Oversampling UART receiver.
// Frame: start(0), INPUT_DATA_WIDTH data bits LSB first, optional parity, stop(1).
// serial_in passes through a reset-to-1 synchronizer chain. One free counter
// times every sample: the start bit is checked at its midpoint, and every
// later bit is taken one full bit period after the previous sample.
// Good frames pulse data_is_valid and update received_data. A parity mismatch
// pulses rx_error. A low stop bit pulses framing_error, and the receiver then
// waits for the line to return high, so a break is not decoded as a stream of
// frames. The state register state_q is a named enum for easy probing.
module uart_rx_oversampled #(
    parameter int INPUT_DATA_WIDTH           = 8,
    parameter int PARITY_ENABLED             = 1,
    parameter int PARITY_TYPE                = 0,
    parameter int CLOCKS_PER_BIT             = 8,
    parameter int NUMBER_OF_RX_SYNCHRONIZERS = 3
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        serial_in,
    output logic [INPUT_DATA_WIDTH-1:0] received_data,
    output logic                        data_is_valid,
    output logic                        rx_error,
    output logic                        framing_error,
    output logic                        o_busy
);

    localparam int CNT_W = $clog2(CLOCKS_PER_BIT);
    localparam int IDX_W = (INPUT_DATA_WIDTH > 1) ? $clog2(INPUT_DATA_WIDTH) : 1;
    localparam int SYN_N = NUMBER_OF_RX_SYNCHRONIZERS;

    // Sample points: mid start bit, then one full bit period apart.
    localparam logic [CNT_W-1:0] CNT_HALF   = CNT_W'(CLOCKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(CLOCKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(INPUT_DATA_WIDTH - 1);
    localparam logic             HAS_PARITY = (PARITY_ENABLED != 0);
    localparam logic             ODD_PARITY = (PARITY_TYPE != 0);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_DATA      = 3'd2,
        S_PARITY    = 3'd3,
        S_STOP      = 3'd4,
        S_WAIT_HIGH = 3'd5
    } state_t;

    logic [SYN_N-1:0]            sync_q, sync_d;
    state_t                      state_q, state_d;
    logic [CNT_W-1:0]            cnt_q, cnt_d;
    logic [IDX_W-1:0]            idx_q, idx_d;
    logic [INPUT_DATA_WIDTH-1:0] shift_q, shift_d;
    logic                        parity_q, parity_d;
    logic [INPUT_DATA_WIDTH-1:0] data_q, data_d;
    logic                        valid_q, valid_d;
    logic                        perr_q, perr_d;
    logic                        ferr_q, ferr_d;
    logic                        busy_q, busy_d;

    logic rx_s;
    logic parity_ok;

    assign rx_s      = sync_q[SYN_N-1];
    assign parity_ok = (parity_q == ((^shift_q) ^ ODD_PARITY));

    // Synchronizer chain: serial_in enters at bit 0 and leaves at the top bit.
    always_comb begin
        sync_d[0] = serial_in;
        for (int i = 1; i < SYN_N; i++) begin
            sync_d[i] = sync_q[i-1];
        end
    end

    // Next-state logic: bit timing, data capture, frame checks and pulses.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        shift_d  = shift_q;
        parity_d = parity_q;
        data_d   = data_q;
        valid_d  = 1'b0;
        perr_d   = 1'b0;
        ferr_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (!rx_s) begin
                    state_d = S_START;
                end
            end

            S_START: begin
                if (cnt_q == CNT_HALF) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    // A high line at mid start bit means the low was only a glitch.
                    state_d = rx_s ? S_IDLE : S_DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            S_DATA: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d          = '0;
                    shift_d[idx_q] = rx_s;
                    idx_d          = idx_q + 1'b1;
                    if (idx_q == IDX_LAST) begin
                        state_d = HAS_PARITY ? S_PARITY : S_STOP;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            S_PARITY: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d    = '0;
                    parity_d = rx_s;
                    state_d  = S_STOP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            S_STOP: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        state_d = S_IDLE;
                        if (!HAS_PARITY || parity_ok) begin
                            valid_d = 1'b1;
                            data_d  = shift_q;
                        end else begin
                            perr_d = 1'b1;
                        end
                    end else begin
                        // A low stop bit hides any parity verdict.
                        ferr_d  = 1'b1;
                        state_d = S_WAIT_HIGH;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            S_WAIT_HIGH: begin
                cnt_d = '0;
                if (rx_s) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // Registered state and outputs; synchronous reset aborts any frame in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q   <= '1;
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            shift_q  <= '0;
            parity_q <= 1'b0;
            data_q   <= '0;
            valid_q  <= 1'b0;
            perr_q   <= 1'b0;
            ferr_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            sync_q   <= sync_d;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            shift_q  <= shift_d;
            parity_q <= parity_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            perr_q   <= perr_d;
            ferr_q   <= ferr_d;
            busy_q   <= busy_d;
        end
    end

    assign received_data = data_q;
    assign data_is_valid = valid_q;
    assign rx_error      = perr_q;
    assign framing_error = ferr_q;
    assign o_busy        = busy_q;

endmodule

// File: tb/tb_uart_rx_oversampled.sv
// Bench for uart_rx_oversampled: a parity-enabled instance (dut) driven by a
// vector table, hand sequences and random frames against a frame-level
// reference, plus a parity-disabled instance (dut_np) for the reset-abort and
// latency checks without a parity bit.
`timescale 1ns/1ps
module tb_uart_rx_oversampled;

    localparam int W      = 8;
    localparam int C      = 8;
    localparam int NS     = 3;
    localparam int LAT_P  = NS + C / 2 + (W + 1 + 1) * C;  // 87
    localparam int LAT_NP = NS + C / 2 + (W + 0 + 1) * C;  // 79
    localparam int FRAME_P = (W + 1 + 2) * C;              // 88

    localparam logic [1:0] K_VALID = 2'd1;
    localparam logic [1:0] K_PERR  = 2'd2;
    localparam logic [1:0] K_FERR  = 2'd3;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic serial_in = 1'b1;
    logic serial_np = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [W-1:0] rd, rd_np;
    logic dv, re, fe, busy;
    logic dv_np, re_np, fe_np, busy_np;

    uart_rx_oversampled #(
        .INPUT_DATA_WIDTH(W), .PARITY_ENABLED(1), .PARITY_TYPE(0),
        .CLOCKS_PER_BIT(C), .NUMBER_OF_RX_SYNCHRONIZERS(NS)
    ) dut (
        .clk(clk), .reset(reset), .serial_in(serial_in),
        .received_data(rd), .data_is_valid(dv), .rx_error(re),
        .framing_error(fe), .o_busy(busy)
    );

    uart_rx_oversampled #(
        .INPUT_DATA_WIDTH(W), .PARITY_ENABLED(0), .PARITY_TYPE(0),
        .CLOCKS_PER_BIT(C), .NUMBER_OF_RX_SYNCHRONIZERS(NS)
    ) dut_np (
        .clk(clk), .reset(reset), .serial_in(serial_np),
        .received_data(rd_np), .data_is_valid(dv_np), .rx_error(re_np),
        .framing_error(fe_np), .o_busy(busy_np)
    );

    // ---------------- bookkeeping ----------------
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_q[$];
    logic [1:0]   exp_kind_q[$];
    int           exp_cyc_q[$];
    logic [W-1:0] model_rd = '0;
    int prev_valid_cyc = 0;
    int last_valid_cyc = 0;

    always @(negedge clk) begin
        logic [1:0] kind;
        logic [W-1:0] e_d;
        logic [1:0] e_k;
        int e_c;
        if (!reset && (dv || re || fe)) begin
            kind = dv ? K_VALID : (re ? K_PERR : K_FERR);
            check("pulse_exclusive", 32'(int'(dv) + int'(re) + int'(fe)), 32'd1);
            if (dv) begin
                prev_valid_cyc = last_valid_cyc;
                last_valid_cyc = cyc;
            end
            if (exp_kind_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_pulse: kind %0d at cycle %0d, none expected", kind, cyc);
            end else begin
                e_d = exp_q.pop_front();
                e_k = exp_kind_q.pop_front();
                e_c = exp_cyc_q.pop_front();
                check("pulse_kind", 32'(kind), 32'(e_k));
                check("pulse_data", 32'(rd), 32'(e_d));
                check("pulse_cycle", 32'(cyc), 32'(e_c));
                check("pulse_busy", 32'(busy), 32'(e_k == K_FERR));
            end
        end
    end

    // Parity-disabled instance: record its pulses for the hand sequences.
    int np_cnt = 0;
    int np_cyc = 0;
    logic [1:0] np_kind = '0;
    logic [W-1:0] np_rd = '0;
    always @(negedge clk) begin
        if (!reset && (dv_np || re_np || fe_np)) begin
            np_cnt++;
            np_cyc  = cyc;
            np_kind = dv_np ? K_VALID : (re_np ? K_PERR : K_FERR);
            np_rd   = rd_np;
        end
    end

    // ---------------- reference model ----------------
    // Outcome of one frame from the frame rules alone (even parity).
    function automatic logic [1:0] ref_outcome(input logic [W-1:0] d, input logic pbit,
                                               input logic stop_b);
        if (stop_b == 1'b0) return K_FERR;
        if (pbit != (^d)) return K_PERR;
        return K_VALID;
    endfunction

    // ---------------- driver tasks ----------------
    // Hold the line at v for n clock edges; first_edge is the edge that
    // captures the first of them.
    task automatic drive_line(input bit np, input logic v, input int n, output int first_edge);
        first_edge = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (i == 0) first_edge = cyc + 1;
            if (np) serial_np = v;
            else serial_in = v;
        end
    endtask

    task automatic send_frame(input bit np, input logic [W-1:0] d, input logic par_flip,
                              input logic stop_b, input logic [1:0] ek,
                              input logic [W-1:0] erd, output int k);
        int unused_edge;
        drive_line(np, 1'b0, C, k);
        if (!np) begin
            exp_q.push_back(erd);
            exp_kind_q.push_back(ek);
            exp_cyc_q.push_back(k + LAT_P);
        end
        for (int i = 0; i < W; i++) drive_line(np, d[i], C, unused_edge);
        if (!np) drive_line(np, (^d) ^ par_flip, C, unused_edge);
        drive_line(np, stop_b, C, unused_edge);
    endtask

    task automatic wait_drain(input int budget);
        for (int i = 0; i < budget && exp_q.size() != 0; i++) @(negedge clk);
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d pulses still expected after %0d cycles", exp_q.size(), budget);
            exp_q.delete();
            exp_kind_q.delete();
            exp_cyc_q.delete();
        end
    endtask

    task automatic wait_np(input int target, input int budget);
        for (int i = 0; i < budget && np_cnt < target; i++) @(negedge clk);
        check("np_pulse_count", 32'(np_cnt), 32'(target));
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [W-1:0] data;
        logic         par_flip;
        logic         stop_b;
        int           hold_low;
        int           gap;
        logic [1:0]   exp_kind;
        logic [W-1:0] exp_rd;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int k, k2, dummy, glen, gap, hold;
        logic [W-1:0] d, b42;
        logic flip, stop_b, pbit;
        logic [1:0] ek;

        vecs[0] = '{8'h5A, 1'b0, 1'b1, 0,  10, K_VALID, 8'h5A};
        vecs[1] = '{8'hA5, 1'b1, 1'b1, 0,  10, K_PERR,  8'h5A};
        vecs[2] = '{8'h3C, 1'b0, 1'b0, 40, 10, K_FERR,  8'h5A};
        vecs[3] = '{8'h81, 1'b0, 1'b1, 0,  10, K_VALID, 8'h81};
        vecs[4] = '{8'h00, 1'b0, 1'b1, 0,  0,  K_VALID, 8'h00};
        vecs[5] = '{8'hFF, 1'b0, 1'b1, 0,  10, K_VALID, 8'hFF};

        // Reset state.
        repeat (3) @(negedge clk);
        check("reset_rd", 32'(rd), 32'd0);
        check("reset_valid", 32'(dv), 32'd0);
        check("reset_rx_error", 32'(re), 32'd0);
        check("reset_framing", 32'(fe), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        reset = 1'b0;
        drive_line(0, 1'b1, 10, dummy);

        // Table-driven frames.
        for (int v = 0; v < 6; v++) begin
            send_frame(0, vecs[v].data, vecs[v].par_flip, vecs[v].stop_b,
                       vecs[v].exp_kind, vecs[v].exp_rd, k);
            if (vecs[v].hold_low > 0) begin
                drive_line(0, 1'b0, vecs[v].hold_low, dummy);
                check("wait_high_busy", 32'(busy), 32'd1);
            end
            drive_line(0, 1'b1, vecs[v].gap, dummy);
            model_rd = vecs[v].exp_rd;
        end
        wait_drain(200);
        check("back_to_back_spacing", 32'(last_valid_cyc - prev_valid_cyc), 32'(FRAME_P));

        // Glitch: 2 low clocks enter START, mid-bit sample is high, no pulse.
        drive_line(0, 1'b0, 2, k);
        drive_line(0, 1'b1, 1, dummy);
        @(negedge clk);
        check("glitch_idle_before", 32'(busy), 32'd0);
        @(negedge clk);
        check("glitch_start_busy", 32'(busy), 32'd1);
        repeat (3) @(negedge clk);
        check("glitch_still_start", 32'(busy), 32'd1);
        @(negedge clk);
        check("glitch_back_idle", 32'(busy), 32'd0);
        drive_line(0, 1'b1, 20, dummy);
        check("glitch_rd_kept", 32'(rd), 32'(model_rd));

        // Reset in the middle of DATA on the parity instance.
        b42 = 8'h42;
        drive_line(0, 1'b0, C, k);
        for (int i = 0; i < 3; i++) drive_line(0, b42[i], C, dummy);
        @(negedge clk);
        reset = 1'b1;
        serial_in = 1'b1;
        @(negedge clk);
        check("abort_rd", 32'(rd), 32'd0);
        check("abort_pulses", 32'({dv, re, fe}), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        reset = 1'b0;
        model_rd = '0;
        drive_line(0, 1'b1, 20, dummy);
        send_frame(0, 8'h42, 1'b0, 1'b1, K_VALID, 8'h42, k);
        model_rd = 8'h42;
        drive_line(0, 1'b1, 4, dummy);
        wait_drain(200);

        // Random frames against the reference model.
        for (int t = 0; t < 40; t++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r == 0) begin
                glen = $urandom_range(1, 4);
                drive_line(0, 1'b0, glen, dummy);
                drive_line(0, 1'b1, 2 * C, dummy);
            end else begin
                d = W'($urandom_range(0, 255));
                flip = (r == 2 || r == 3);
                stop_b = (r != 1);
                pbit = (^d) ^ flip;
                ek = ref_outcome(d, pbit, stop_b);
                if (ek == K_VALID) model_rd = d;
                send_frame(0, d, flip, stop_b, ek, model_rd, k);
                if (!stop_b) begin
                    hold = $urandom_range(0, 20);
                    gap = $urandom_range(1, 10);
                    drive_line(0, 1'b0, hold, dummy);
                end else begin
                    gap = $urandom_range(0, 12);
                end
                drive_line(0, 1'b1, gap, dummy);
            end
        end
        drive_line(0, 1'b1, 4, dummy);
        wait_drain(300);

        // Parity-disabled instance: reset mid-DATA, then two back-to-back frames.
        drive_line(1, 1'b0, C, k);
        for (int i = 0; i < 3; i++) drive_line(1, b42[i], C, dummy);
        @(negedge clk);
        reset = 1'b1;
        serial_np = 1'b1;
        @(negedge clk);
        check("np_abort_rd", 32'(rd_np), 32'd0);
        check("np_abort_pulses", 32'({dv_np, re_np, fe_np}), 32'd0);
        check("np_abort_busy", 32'(busy_np), 32'd0);
        check("main_rd_after_reset", 32'(rd), 32'd0);
        reset = 1'b0;
        model_rd = '0;
        np_cnt = 0;
        drive_line(1, 1'b1, 20, dummy);
        send_frame(1, 8'h42, 1'b0, 1'b1, K_VALID, 8'h42, k);
        send_frame(1, 8'h07, 1'b0, 1'b1, K_VALID, 8'h07, k2);
        wait_np(1, 10);
        drive_line(1, 1'b1, 4, dummy);
        wait_np(2, 200);
        check("np_last_kind", 32'(np_kind), 32'(K_VALID));
        check("np_last_rd", 32'(np_rd), 32'h07);
        check("np_latency", 32'(np_cyc), 32'(k2 + LAT_NP));
        check("np_frame_start_gap", 32'(k2 - k), 32'((W + 2) * C));
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global time bound.
    initial begin
        #1000000;
        n_fail++;
        $display("FAIL watchdog: simulation did not finish by cycle %0d", cyc);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "watchdog expired");
    end

endmodule
